rr_mux4_arbiter: RTL
====================

Name: rr_mux4_arbiter

Overview:
Round-robin arbiter and sequencer that shares one DW-bit output channel among four requesters through a 4:1 datapath multiplexer. It drives the 2-bit mux select and a one-hot grant vector, and holds each grant for a bounded burst. Transfers to the downstream consumer use a valid/ready handshake. It sits between four producer blocks and a single consumer.

Parameters:
DW, 8, data width per requester and of the output
MAX_BURST, 4, maximum transfers per grant before forced release (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  4  request per requester; held high while that requester has data
din  input  4*DW  packed requester data; requester i occupies din[i*DW +: DW]
grant  output  4  one-hot grant; all zero when idle
sel  output  2  mux select = index of granted requester
dout  output  DW  selected data; zero when dout_valid=0
dout_valid  output  1  output data valid
dout_ready  input  1  consumer accepts data this cycle
busy  output  1  high while in GRANT state

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset (async assert, takes effect immediately): state=IDLE, grant=0, sel=0, rr pointer ptr=0, burst count cnt=0, dout_valid=0, dout=0, busy=0.
- States: IDLE, GRANT.
- IDLE: if req!=0, choose first i with req[i]=1 scanning ptr, ptr+1, ... mod 4. Next cycle: state=GRANT, sel=i, grant=1<<i, cnt=0. If req==0, stay in IDLE.
- Latency: req rise with IDLE -> grant and dout_valid high on the next rising edge (1 cycle).
- GRANT: dout_valid = req[sel]; dout = din slice[sel] when dout_valid, else 0 (combinational through the 4:1 mux).
- Transfer = dout_valid && dout_ready; each transfer increments cnt.
- Release on the first of these:
  (a) req[sel]=0 (no transfer that cycle);
  (b) a transfer with cnt==MAX_BURST-1.
  On release: next state=IDLE, grant=0, ptr=sel+1 mod 4, cnt=0.
- Release always costs one IDLE bubble cycle. Arbitration occurs only in IDLE, so worst-case wait for a requester is 3 full bursts plus 3 bubbles plus 1 cycle.
- No preemption: new or other requests during GRANT never change sel.
- dout_ready low: grant holds indefinitely while req[sel]=1; dout stays stable.
- MAX_BURST=1: release after every transfer.
- cnt width = max(1, clog2(MAX_BURST)); cnt never wraps, because release occurs at MAX_BURST-1.
- ptr wrap: 3+1 -> 0.
- Simultaneous requests in IDLE: the pointer order decides; after reset ptr=0, so requester 0 has priority.
- Reset mid-GRANT: grant and dout_valid drop asynchronously; no partial state survives.
- busy = (state==GRANT).

Decomposition:
- Shared package: NUM_REQ=4, SEL_W=2, state encoding constants (IDLE=0, GRANT=1).
- Sub-module: mux4_dw, a parameterized DW-bit 4:1 multiplexer (select in, four DW inputs, one output), instantiated once for dout.
- The round-robin pick is a local function in the arbiter.

Test Plan:
- Reset mid-burst: assert reset while granted to 1 -> grant=0000, dout_valid=0, dout=0 immediately; after release, req=0001 -> grant 0001.
- Single requester: req=0100, din slice2=8'hA5, dout_ready=1 -> cycle+1 grant=0100, sel=2, dout=A5. After 4 transfers: grant=0000 for 1 cycle, then re-grant 0100.
- Round-robin: req=1111 held, ready=1 -> grant order 0001, 0010, 0100, 1000, 0001, each for 4 valid cycles separated by 1 idle cycle.
- Backpressure: granted to 3, ready=0 for 10 cycles -> grant=1000 held, dout stable, cnt=0. Then ready=1 -> exactly 4 transfers, then release.
- Early drop: granted to 1, req[1] drops after 2 transfers -> next cycle grant=0000, ptr=2. With req=0011 next, grant goes to 0 (scan 2, 3, 0).
- MAX_BURST=1 instance with req=1010 -> alternating grants 0010, 1000, each with 1 transfer and 1 bubble.

Source files
------------

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared constants for the four-way round-robin arbiter and its datapath mux.
package rr_mux4_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

// File: rtl/rr_mux4_arbiter_mux4_dw.sv
// DW-bit 4:1 multiplexer; requester i occupies din[i*DW +: DW].
module mux4_dw
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [NUM_REQ*DW-1:0] din,
    output logic [DW-1:0]         dout
);
    always_comb begin
        dout = din[DW-1:0];
        case (sel)
            2'd0: dout = din[0*DW +: DW];
            2'd1: dout = din[1*DW +: DW];
            2'd2: dout = din[2*DW +: DW];
            2'd3: dout = din[3*DW +: DW];
            default: dout = din[DW-1:0];
        endcase
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one valid/ready output among four requesters,
// holding each grant for at most MAX_BURST transfers.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] din,
    output logic [NUM_REQ-1:0]    grant,
    output logic [SEL_W-1:0]      sel,
    output logic [DW-1:0]         dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    // Handshake: a transfer happens in any cycle where dout_valid and
    // dout_ready are both high; dout is held stable while valid waits on ready.
    logic [0:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    mux_out;
    logic             xfer;

    // First requester at or after the pointer, wrapping modulo four.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        rr_pick = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign busy       = (state == ST_GRANT);
    assign grant      = busy ? (NUM_REQ'(1) << sel) : '0;
    assign dout_valid = busy & req[sel];
    assign xfer       = dout_valid & dout_ready;
    assign dout       = dout_valid ? mux_out : '0;

    mux4_dw #(.DW(DW)) u_mux (
        .sel  (sel),
        .din  (din),
        .dout (mux_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_GRANT;
                        sel   <= rr_pick(req, ptr);
                        cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    // A dropped request ends the burst; so does the last allowed transfer.
                    if (!req[sel] || (xfer && cnt == CNT_LAST)) begin
                        state <= ST_IDLE;
                        ptr   <= sel + SEL_W'(1);
                        cnt   <= '0;
                    end else if (xfer) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
